// File: rtl/lab3_dg_multiseg.sv
// lab3_dg_multiseg: key-history capture with a multiplexed multi-digit scan.
//
// A rising edge on key_valid pushes key_code into a NUM_DIGITS-deep history
// (newest in hist[0], oldest discarded when full). An independent prescaler
// walks digit_idx across the digits, presenting hist[digit_idx] on digit_code
// and one active-low anode per slot, with one all-off dead cycle at the start
// of each slot.
//
// Parameters: NUM_DIGITS (2..8), CODE_W, REFRESH_DIV (2..65536 cycles/slot).
// Ports:
//   int_osc     in   system clock, rising edge
//   reset       in   asynchronous active-low reset
//   key_valid   in   level key-pressed indication
//   key_code    in   code captured on a new key
//   clear       in   synchronous history clear (wins over a capture)
//   anode       out  active-low digit enables, at most one low
//   digit_code  out  code of the digit currently scanned
//   digit_idx   out  index of the digit currently scanned
//   digit_blank out  current slot blanked
// Optional: define LAB3_DG_LEADING_BLANK_EN to blank never-written digits.

// One history stage: holds a code and its written flag.
module lab3_dg_hist_cell #(
  parameter int CODE_W = 8
) (
  input  logic              int_osc,
  input  logic              reset,
  input  logic              clr,
  input  logic              shift,
  input  logic [CODE_W-1:0] d_code,
  input  logic              d_valid,
  output logic [CODE_W-1:0] q_code,
  output logic              q_valid
);
  always_ff @(posedge int_osc or negedge reset) begin
    if (!reset) begin
      q_code  <= '0;
      q_valid <= 1'b0;
    end else if (clr) begin
      q_code  <= '0;
      q_valid <= 1'b0;
    end else if (shift) begin
      q_code  <= d_code;
      q_valid <= d_valid;
    end
  end
endmodule

module lab3_dg_multiseg #(
  parameter int NUM_DIGITS  = 2,
  parameter int CODE_W      = 8,
  parameter int REFRESH_DIV = 16384
) (
  input  logic                          int_osc,
  input  logic                          reset,
  input  logic                          key_valid,
  input  logic [CODE_W-1:0]             key_code,
  input  logic                          clear,
  output logic [NUM_DIGITS-1:0]         anode,
  output logic [CODE_W-1:0]             digit_code,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
  output logic                          digit_blank
);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int CNT_W = $clog2(REFRESH_DIV);

  logic                             key_prev;
  logic                             cap;
  logic [NUM_DIGITS-1:0][CODE_W-1:0] hist_code;
  logic [NUM_DIGITS-1:0]            hist_vld;
  logic [CNT_W-1:0]                 cnt;

  // Edge detect: key_prev resets low so a key already held at reset release
  // is captured on the first clock.
  always_ff @(posedge int_osc or negedge reset) begin
    if (!reset) key_prev <= 1'b0;
    else        key_prev <= key_valid;
  end

  assign cap = key_valid & ~key_prev;

  // History shift chain; stage 0 takes the new key, stage g takes stage g-1.
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_hist
    if (g == 0) begin : g_head
      lab3_dg_hist_cell #(.CODE_W(CODE_W)) u_cell (
        .int_osc (int_osc),
        .reset   (reset),
        .clr     (clear),
        .shift   (cap),
        .d_code  (key_code),
        .d_valid (1'b1),
        .q_code  (hist_code[g]),
        .q_valid (hist_vld[g])
      );
    end else begin : g_tail
      lab3_dg_hist_cell #(.CODE_W(CODE_W)) u_cell (
        .int_osc (int_osc),
        .reset   (reset),
        .clr     (clear),
        .shift   (cap),
        .d_code  (hist_code[g-1]),
        .d_valid (hist_vld[g-1]),
        .q_code  (hist_code[g]),
        .q_valid (hist_vld[g])
      );
    end
  end

  // Scan timing is free-running and never touched by capture or clear.
  always_ff @(posedge int_osc or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      digit_idx <= '0;
    end else if (cnt == CNT_W'(REFRESH_DIV - 1)) begin
      cnt       <= '0;
      digit_idx <= (digit_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : digit_idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign digit_code = hist_code[digit_idx];

  // Anode decode from registered cnt/digit_idx only, so a single bit can be
  // low; cnt==0 is the inter-digit dead cycle.
  always_comb begin
    anode       = '1;
    digit_blank = 1'b0;
`ifdef LAB3_DG_LEADING_BLANK_EN
    digit_blank = ~hist_vld[digit_idx];
`endif
    if (cnt != '0 && !digit_blank) anode[digit_idx] = 1'b0;
  end

`ifndef LAB3_DG_LEADING_BLANK_EN
  // Written flags only drive blanking; keep them observable for lint.
  logic unused_vld;
  assign unused_vld = ^hist_vld;
`endif
endmodule

// File: tb/tb_lab3_dg_multiseg.sv
// Bench for lab3_dg_multiseg (NUM_DIGITS=4, CODE_W=8, REFRESH_DIV=4).
// Reference: time-since-reset gives slot position, a plain array holds the
// key history with a fill count.
module tb_lab3_dg_multiseg;
  localparam int ND = 4;
  localparam int CW = 8;
  localparam int RD = 4;

  logic          int_osc = 1'b0;
  logic          reset = 1'b0;
  logic          key_valid = 1'b0;
  logic [CW-1:0] key_code = '0;
  logic          clear = 1'b0;
  logic [ND-1:0] anode;
  logic [CW-1:0] digit_code;
  logic [1:0]    digit_idx;
  logic          digit_blank;

  int tests = 0;
  int fails = 0;

  // Reference state
  int          t;
  logic [7:0]  mh [ND];
  int          nv;
  logic        kp;

  lab3_dg_multiseg #(.NUM_DIGITS(ND), .CODE_W(CW), .REFRESH_DIV(RD)) dut (
    .int_osc     (int_osc),
    .reset       (reset),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .clear       (clear),
    .anode       (anode),
    .digit_code  (digit_code),
    .digit_idx   (digit_idx),
    .digit_blank (digit_blank)
  );

  always #5 int_osc = ~int_osc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h (t=%0d)", tag, obs, exp, t);
    end
  endtask

  task automatic model_reset();
    t = 0; nv = 0; kp = 1'b0;
    for (int i = 0; i < ND; i++) mh[i] = '0;
  endtask

  // Compare all outputs to what the reference implies for the current time.
  task automatic check_outputs();
    int   cnt, idx;
    logic vld, blank;
    logic [ND-1:0] an;
    cnt = t % RD;
    idx = (t / RD) % ND;
    vld = (idx < nv);
`ifdef LAB3_DG_LEADING_BLANK_EN
    blank = !vld;
`else
    blank = 1'b0;
`endif
    an = (cnt == 0 || blank) ? '1 : ~(ND'(1) << idx);
    chk("digit_idx", 32'(digit_idx), 32'(idx));
    chk("anode", 32'(anode), 32'(an));
    chk("digit_code", 32'(digit_code), 32'(mh[idx]));
    chk("digit_blank", 32'(digit_blank), 32'(blank));
  endtask

  // One clock: advance the reference with the inputs seen at the edge.
  task automatic tick();
    @(posedge int_osc);
    if (clear) begin
      nv = 0;
      for (int i = 0; i < ND; i++) mh[i] = '0;
    end else if (key_valid && !kp) begin
      for (int i = ND - 1; i > 0; i--) mh[i] = mh[i-1];
      mh[0] = key_code;
      if (nv < ND) nv++;
    end
    kp = key_valid;
    t++;
    #1;
    check_outputs();
  endtask

  task automatic press(input logic [7:0] code);
    key_valid = 1'b1; key_code = code; tick();
    key_valid = 1'b0; tick();
  endtask

  // Directed check of the history through the scan, one full rotation.
  task automatic expect_hist(input string tag, input logic [ND-1:0][7:0] e);
    for (int k = 0; k < RD * ND; k++) begin
      tick();
      if ((t % RD) != 0) begin
`ifdef LAB3_DG_LEADING_BLANK_EN
        if (e[digit_idx] != 8'h00)
`endif
        chk(tag, 32'(digit_code), 32'(e[digit_idx]));
      end
    end
  endtask

  initial begin
    logic [ND-1:0] onehot [ND];
    onehot[0] = 4'b1110; onehot[1] = 4'b1101; onehot[2] = 4'b1011; onehot[3] = 4'b0111;
    model_reset();
    repeat (2) @(posedge int_osc);
    #1;
    chk("rst_anode", 32'(anode), 32'hF);
    chk("rst_idx", 32'(digit_idx), 32'h0);
    chk("rst_code", 32'(digit_code), 32'h0);
    #2 reset = 1'b1;
    check_outputs();

    // Scan: slot sequence with literal one-hot patterns
    for (int k = 0; k < 20; k++) begin
      tick();
      if ((t % RD) == 0) chk("scan_dead", 32'(anode), 32'hF);
      else chk("scan_onehot", 32'(anode), 32'(onehot[(t / RD) % ND]));
    end

`ifndef LAB3_DG_LEADING_BLANK_EN
    // Capture: short pulses then a long hold counts once
    press(8'hDE);
    press(8'hE7);
    expect_hist("cap2", {8'h00, 8'h00, 8'hDE, 8'hE7});
    key_valid = 1'b1; key_code = 8'hBB;
    repeat (10) tick();
    key_valid = 1'b0; tick();
    expect_hist("hold", {8'h00, 8'hDE, 8'hE7, 8'hBB});

    // Overflow: oldest discarded
    clear = 1'b1; tick(); clear = 1'b0;
    for (int k = 1; k <= 5; k++) press(8'(k));
    expect_hist("ovf", {8'h02, 8'h03, 8'h04, 8'h05});

    // Clear colliding with a key edge drops the key
    key_valid = 1'b1; key_code = 8'h77; clear = 1'b1; tick();
    clear = 1'b0;
    repeat (3) tick();
    expect_hist("clr_col", {8'h00, 8'h00, 8'h00, 8'h00});
    key_valid = 1'b0; tick();
    press(8'h77);
    expect_hist("clr_recap", {8'h00, 8'h00, 8'h00, 8'h77});

    // Random traffic against the reference
    for (int k = 0; k < 400; k++) begin
      key_valid = ($urandom % 3) == 0;
      key_code  = 8'($urandom);
      clear     = ($urandom % 25) == 0;
      tick();
    end
    key_valid = 1'b0; clear = 1'b0;

    // Reset asserted mid-slot at digit 2
    for (int k = 0; k < 64 && (t % (RD * ND)) != 9; k++) tick();
    chk("pre_rst_idx", 32'(digit_idx), 32'h2);
    reset = 1'b0;
    #1;
    chk("arst_idx", 32'(digit_idx), 32'h0);
    chk("arst_anode", 32'(anode), 32'hF);
    chk("arst_code", 32'(digit_code), 32'h0);
    model_reset();
    #2 reset = 1'b1;
    tick();
    chk("post_rst_anode", 32'(anode), 32'hE);
    for (int k = 0; k < 20; k++) tick();
`else
    // Leading blank: only the written digit lights
    press(8'hDE);
    for (int k = 0; k < RD * ND * 2; k++) begin
      tick();
      if (digit_idx == 2'd0) begin
        chk("blk_code0", 32'(digit_code), 32'hDE);
        chk("blk_blank0", 32'(digit_blank), 32'h0);
        if ((t % RD) != 0) chk("blk_anode0", 32'(anode), 32'hE);
      end else begin
        chk("blk_anode", 32'(anode), 32'hF);
        chk("blk_blank", 32'(digit_blank), 32'h1);
      end
    end
    for (int k = 0; k < 200; k++) begin
      key_valid = ($urandom % 4) == 0;
      key_code  = 8'($urandom);
      clear     = ($urandom % 30) == 0;
      tick();
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/lab3_dg_multiseg.md
LAB3_DG_MULTISEG -- requirements
Module: lab3_dg_multiseg

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 2: number of display digits / history depth, legal range 2..8.
REQ-002 SHALL have parameter CODE_W, default 8: width of one key/segment code.
REQ-003 SHALL have parameter REFRESH_DIV, default 16384: int_osc cycles per digit scan slot, legal range 2..65536.
REQ-004 SHALL have port int_osc  input  1  single system clock; all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port key_valid  input  1  level "key pressed" indication, synchronous to int_osc.
REQ-007 SHALL have port key_code  input  CODE_W  code captured on a new key.
REQ-008 SHALL have port clear  input  1  synchronous history clear.
REQ-009 SHALL have port anode  output  NUM_DIGITS  active-low digit enables.
REQ-010 SHALL have port digit_code  output  CODE_W  code of the currently scanned digit.
REQ-011 SHALL have port digit_idx  output  $clog2(NUM_DIGITS)  currently scanned digit index.
REQ-012 SHALL have port digit_blank  output  1  high when the current slot is blanked.

Function
REQ-013 SHALL register key_valid into key_prev each cycle; a capture event is key_valid=1 and key_prev=0.
REQ-014 SHALL, on a capture event, shift history: hist[0]<=key_code, hist[i]<=hist[i-1], valid[0]<=1, valid[i]<=valid[i-1]; new contents visible the cycle after the edge.
REQ-015 SHALL capture exactly once per key_valid high period regardless of hold length.
REQ-016 SHALL discard hist[NUM_DIGITS-1] when full; no overflow flag.
REQ-017 SHALL, on clear=1, zero all hist and valid bits next cycle; clear wins over a simultaneous capture event (key is dropped, key_prev still updates).
REQ-018 SHALL run prescaler cnt 0..REFRESH_DIV-1, wrapping to 0; at cnt=REFRESH_DIV-1, digit_idx increments, wrapping NUM_DIGITS-1 -> 0.
REQ-019 SHALL drive anode all-ones (dead time) whenever cnt=0, else anode[digit_idx]=0 and all other bits 1.
REQ-020 SHALL never drive more than one anode bit low in any cycle.
REQ-021 SHALL drive digit_code=hist[digit_idx] combinationally from registered state, glitch-free across capture (history and scan are independent registers).
REQ-022 SHALL not affect scan timing from capture or clear.

Reset
REQ-023 SHALL, while reset=0, asynchronously force hist=0, valid=0, key_prev=0, cnt=0, digit_idx=0.
REQ-024 SHALL present after reset: anode all-ones (cnt=0), digit_code=0, digit_idx=0, digit_blank per REQ-026/027.
REQ-025 SHALL treat key_valid already high at reset release as a capture event on the first clock (key_prev reset to 0).

Configuration
REQ-026 SHALL, with LAB3_DG_LEADING_BLANK_EN defined, force anode all-ones and digit_blank=1 during any slot whose valid[digit_idx]=0.
REQ-027 SHALL, without LAB3_DG_LEADING_BLANK_EN, display every slot per REQ-019 (never-written digits show code 0) and tie digit_blank to 0.

Verification (NUM_DIGITS=4, CODE_W=8, REFRESH_DIV=4, macro off unless stated)
REQ-028 SHALL check reset: assert reset=0 mid-slot at digit_idx=2 -> digit_idx=0, anode=4'b1111 immediately; after release, cycle 1 anode=4'b1110.
REQ-029 SHALL check scan: digit_idx sequence 0,1,2,3,0 at 4-cycle slots; each slot anode all-ones 1 cycle then one-hot low 3 cycles (4'b1110,4'b1101,4'b1011,4'b0111).
REQ-030 SHALL check capture: key_valid pulses with 8'hDE then 8'hE7 -> hist[0]=8'hE7, hist[1]=8'hDE; key_valid held 10 cycles with 8'hBB -> single capture, hist[0]=8'hBB, hist[1]=8'hE7.
REQ-031 SHALL check overflow: keys 8'h01..8'h05 -> hist[3..0]=8'h02,8'h03,8'h04,8'h05; digit_code=8'h05 when digit_idx=0.
REQ-032 SHALL check clear collision: clear=1 on same cycle as key edge with 8'h77 -> all hist=0, no later capture until key_valid falls and rises.
REQ-033 SHALL check macro on: one key 8'hDE after reset -> slot 0 anode 4'b1110, digit_code=8'hDE, digit_blank=0; slots 1-3 anode 4'b1111, digit_blank=1.
